md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  Multi-cycle multiply/divide unit; consumes the HI/LO instructions the single-cycle ALU does not execute.
//  Sits in EX beside the ALU: receives operands A/B and a decoded md_op.
//  Holds the architectural HI/LO registers and exposes busy so the hazard unit can stall.
//  The hazard unit stalls on (start | busy) for the instructions mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
// PARAMETERS
//  MUL_CYCLES  5   cycles from start edge to HI/LO update for MULT/MULTU (>=1)
//  DIV_CYCLES  32  iterations of the radix-2 restoring divider (fixed = data width; not for override)
// PORTS
//  clk     in   1   single clock, rising edge
//  reset   in   1   asynchronous, active-high; clears all state
//  start   in   1   one-cycle pulse: launch md_op with a/b this edge
//  md_op   in   3   `MD_MULT, `MD_MULTU, `MD_DIV, `MD_DIVU, `MD_MTHI, `MD_MTLO (others = no-op)
//  a       in   32  rs operand (dividend / multiplicand / MTHI-MTLO source)
//  b       in   32  rt operand (divisor / multiplier)
//  busy    out  1   operation in flight
//  hi      out  32  HI register (registered)
//  lo      out  32  LO register (registered)
// BEHAVIOUR
//  Reset: busy=0, hi=0, lo=0, counter=0, FSM=IDLE; asserting reset mid-operation aborts it, no HI/LO write.
//  FSM states: IDLE, MUL, DIV.
//   IDLE + start + MULT/MULTU -> MUL: product latched at start edge (signed 64b for MULT, unsigned for MULTU).
//   MUL: busy=1 for exactly MUL_CYCLES cycles; at edge N+MUL_CYCLES: {hi,lo}<=product, busy<=0, ->IDLE.
//   IDLE + start + DIV/DIVU -> DIV: latch |a|,|b| (raw for DIVU) and the quotient/remainder signs.
//   DIV: one restoring step per cycle; at edge N+32: lo<=quotient, hi<=remainder, busy<=0, ->IDLE.
//   Signed DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
//   Divide by zero (b==0, DIV or DIVU): lo<=32'hFFFF_FFFF, hi<=a; same 32-cycle latency.
//   DIV 0x80000000 / 0xFFFFFFFF: lo<=32'h8000_0000, hi<=0 (falls out of abs/negate arithmetic; no special case).
//   MTHI/MTLO with start in IDLE: hi<=a / lo<=a at that edge; busy stays 0.
//  start while busy=1: ignored entirely (hazard unit guarantees none; bench checks no corruption).
//  Unknown md_op with start: no-op, stays IDLE.
//  hi/lo change only on completion, on MTHI/MTLO, or on reset; mfhi/mflo read hi/lo combinationally outside.
//  busy rises at the edge after start (start edge N -> busy=1 from N to completion edge).
//   The hazard unit therefore combines start|busy.
//  Counter width: clog2(max(MUL_CYCLES,DIV_CYCLES))+1; no wrap-around is reachable.
// STRUCTURE
//  head.v (shared): add `MD_MULT=3'd1, `MD_MULTU=3'd2, `MD_DIV=3'd3, `MD_DIVU=3'd4, `MD_MTHI=3'd5, `MD_MTLO=3'd6.
//   These sit alongside the existing `ALU_* codes.
//  Sub-module md_div_iter: unsigned 32-step restoring divider.
//   Interface: clk, reset, load, dividend, divisor -> quotient, remainder, done.
//   md_unit owns the FSM, the sign pre/post-fix, the multiply delay line and HI/LO.
// TESTING
//  MULT a=-3 b=5 -> busy for 5 cycles, then hi=FFFFFFFF lo=FFFFFFF1.
//  MULTU a=FFFFFFFF b=2 -> hi=00000001 lo=FFFFFFFE.
//  DIV a=-7 b=2 -> after 32 cycles lo=FFFFFFFD hi=FFFFFFFF; DIVU a=7 b=2 -> lo=3 hi=1.
//  DIVU a=7 b=0 -> lo=FFFFFFFF hi=00000007, busy 32 cycles.
//  MTLO a=1234 in IDLE -> lo=1234 next edge, busy never 1.
//   MTHI or MULT pulsed mid-DIV -> ignored; DIV result unchanged.
//  Reset asserted at cycle 10 of a DIV (async, between edges) -> busy/hi/lo=0 immediately.
//   A new MULT started after reset completes normally.

Source files
------------

// File: rtl/md_unit_pkg.sv
// ---------------------------------------------------------------------------
// md_unit_pkg
// Shared definitions for the multiply/divide unit: operation codes (the same
// values the decoder's MD_* codes carry next to the ALU codes), FSM state
// encoding, divider width and a small absolute-value helper.
// ---------------------------------------------------------------------------
package md_unit_pkg;

  // md_op encodings. Code 0 and code 7 are no-ops.
  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  // The divider retires one quotient bit per cycle, so its iteration count
  // equals the data width.
  localparam int DATA_W     = 32;
  localparam int DIV_CYCLES = DATA_W;

  // Two's-complement magnitude. 0x8000_0000 maps to itself, which is the
  // correct unsigned magnitude 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// ---------------------------------------------------------------------------
// md_unit_if
// Bundles the EX-stage connection to the multiply/divide unit.
//   start  : one-cycle launch pulse, sampled on the rising clock edge
//   md_op  : operation to launch with start
//   a, b   : rs / rt operands
//   busy   : operation in flight (registered)
//   hi, lo : architectural HI/LO registers
//   state  : FSM state, debug visibility only
// Handshake: start is a single-cycle request that is accepted only when the
// FSM is IDLE; it is never back-pressured. busy rises at the accepting edge and
// falls at the completion edge, so the hazard logic must stall on start|busy.
// ---------------------------------------------------------------------------
interface md_unit_if;
  import md_unit_pkg::*;

  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  md_state_e   state;

  modport master (output start, md_op, a, b, input busy, hi, lo, state);
  modport slave  (input start, md_op, a, b, output busy, hi, lo, state);
endinterface

// File: rtl/md_div_iter.sv
// ---------------------------------------------------------------------------
// md_div_iter
// Unsigned radix-2 restoring divider, one quotient bit per clock.
//   clk, reset : clock, asynchronous active-high reset
//   load       : capture dividend/divisor and start a new division
//   dividend   : unsigned dividend
//   divisor    : unsigned divisor
//   quotient   : quotient after the step taken in the current cycle
//   remainder  : remainder after the step taken in the current cycle
//   done       : high in the cycle whose step is the last one; quotient and
//                remainder are then final and valid for that clock edge
// A load at edge N performs steps on edges N+1 .. N+DIV_CYCLES, with done high
// in the cycle ending at edge N+DIV_CYCLES. Divisor 0 yields all-ones quotient.
// ---------------------------------------------------------------------------
module md_div_iter
  import md_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  localparam int CNT_W = $clog2(DIV_CYCLES);

  logic [31:0]      r_rem;
  logic [31:0]      r_quo;   // dividend bits shift out as quotient bits shift in
  logic [31:0]      r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;

  logic [32:0]      w_shift;
  logic [32:0]      w_diff;
  logic [31:0]      w_rem_next;
  logic [31:0]      w_quo_next;
  logic             w_done;

  // Partial remainder stays below the divisor, so a borrow out of the 33-bit
  // subtraction shows up exactly in bit 32.
  assign w_shift    = {r_rem, r_quo[31]};
  assign w_diff     = w_shift - {1'b0, r_div};
  assign w_rem_next = w_diff[32] ? w_shift[31:0] : w_diff[31:0];
  assign w_quo_next = {r_quo[30:0], ~w_diff[32]};
  assign w_done     = r_run && (r_cnt == CNT_W'(DIV_CYCLES - 1));

  assign quotient   = w_quo_next;
  assign remainder  = w_rem_next;
  assign done       = w_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (load) begin
      r_rem <= '0;
      r_quo <= dividend;
      r_div <= divisor;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      if (w_done) begin
        r_run <= 1'b0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit
// Multi-cycle multiply/divide unit beside the ALU in EX. Owns HI/LO.
//   clk   : clock, rising edge
//   reset : asynchronous active-high; aborts any operation, clears HI/LO
//   bus   : md_unit_if slave (start, md_op, a, b -> busy, hi, lo, state)
// MULT/MULTU: product computed at the start edge, held for MUL_CYCLES cycles,
//   then written to {hi,lo}.
// DIV/DIVU: magnitudes fed to md_div_iter, signs re-applied on completion
//   32 cycles later (quotient toward zero, remainder signed like dividend).
//   Divide by zero writes lo=all-ones, hi=a.
// MTHI/MTLO: write hi/lo at the start edge, busy stays low.
// start while not IDLE is ignored.
// ---------------------------------------------------------------------------
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 5
) (
  input  logic clk,
  input  logic reset,
  md_unit_if.slave bus
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  md_state_e        r_state;
  logic             r_busy;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      r_prod;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_dzero;
  logic [31:0]      r_a_raw;

  logic             w_accept;
  logic             w_mul_signed;
  logic             w_div_signed;
  logic [63:0]      w_a64;
  logic [63:0]      w_b64;
  logic [63:0]      w_prod;
  logic             w_div_load;
  logic [31:0]      w_div_a;
  logic [31:0]      w_div_b;
  logic [31:0]      w_quo;
  logic [31:0]      w_rem;
  logic             w_div_done;
  logic [31:0]      w_quo_fix;
  logic [31:0]      w_rem_fix;

  assign w_accept     = bus.start && (r_state == ST_IDLE);
  assign w_mul_signed = (bus.md_op == MD_MULT);
  assign w_div_signed = (bus.md_op == MD_DIV);

  // Low 64 bits of a 64x64 product of the extended operands are the correct
  // 32x32 product for both signed and unsigned, so one multiplier serves both.
  assign w_a64  = w_mul_signed ? {{32{bus.a[31]}}, bus.a} : {32'd0, bus.a};
  assign w_b64  = w_mul_signed ? {{32{bus.b[31]}}, bus.b} : {32'd0, bus.b};
  assign w_prod = w_a64 * w_b64;

  assign w_div_load = w_accept && ((bus.md_op == MD_DIV) || (bus.md_op == MD_DIVU));
  assign w_div_a    = w_div_signed ? abs32(bus.a) : bus.a;
  assign w_div_b    = w_div_signed ? abs32(bus.b) : bus.b;

  md_div_iter u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (w_div_load),
    .dividend  (w_div_a),
    .divisor   (w_div_b),
    .quotient  (w_quo),
    .remainder (w_rem),
    .done      (w_div_done)
  );

  assign w_quo_fix = r_q_neg ? (~w_quo + 32'd1) : w_quo;
  assign w_rem_fix = r_r_neg ? (~w_rem + 32'd1) : w_rem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_prod  <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_dzero <= 1'b0;
      r_a_raw <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (bus.md_op)
              MD_MULT, MD_MULTU: begin
                r_prod  <= w_prod;
                r_cnt   <= CNT_W'(MUL_CYCLES - 1);
                r_busy  <= 1'b1;
                r_state <= ST_MUL;
              end
              MD_DIV, MD_DIVU: begin
                r_q_neg <= w_div_signed && (bus.a[31] ^ bus.b[31]);
                r_r_neg <= w_div_signed && bus.a[31];
                r_dzero <= (bus.b == 32'd0);
                r_a_raw <= bus.a;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
                r_state <= ST_DIV;
              end
              MD_MTHI: r_hi <= bus.a;
              MD_MTLO: r_lo <= bus.a;
              default: ;
            endcase
          end
        end

        ST_MUL: begin
          if (r_cnt == '0) begin
            r_hi    <= r_prod[63:32];
            r_lo    <= r_prod[31:0];
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        ST_DIV: begin
          // r_cnt tracks elapsed divide steps for visibility only; the
          // divider's own done decides completion.
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_div_done) begin
            if (r_dzero) begin
              r_lo <= 32'hFFFF_FFFF;
              r_hi <= r_a_raw;
            end else begin
              r_lo <= w_quo_fix;
              r_hi <= w_rem_fix;
            end
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;
  assign bus.state = r_state;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
  import md_unit_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  md_unit_if bus ();

  md_unit #(.MUL_CYCLES(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change on the falling edge, outputs sampled there too
  task automatic do_start(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.a     = av;
    bus.b     = bv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.md_op = 3'd0;
  endtask

  // Counts falling edges at which busy is seen high; bounded at 100.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_checks++; if (bus.hi !== 32'h0) begin n_errors++; $display("FAIL reset_hi got=%h exp=00000000", bus.hi); end
    n_checks++; if (bus.lo !== 32'h0) begin n_errors++; $display("FAIL reset_lo got=%h exp=00000000", bus.lo); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.state !== ST_IDLE) begin n_errors++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
  endtask

  task automatic test_move();
    logic seen_busy;
    seen_busy = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = MD_MTLO; bus.a = 32'h0000_1234; bus.b = 32'h0;
    @(negedge clk);
    seen_busy |= bus.busy;
    n_checks++; if (bus.lo !== 32'h0000_1234) begin n_errors++; $display("FAIL mtlo_lo got=%h exp=00001234", bus.lo); end
    n_checks++; if (bus.hi !== 32'h0) begin n_errors++; $display("FAIL mtlo_hi got=%h exp=00000000", bus.hi); end
    bus.md_op = MD_MTHI; bus.a = 32'hCAFE_BABE;
    @(negedge clk);
    seen_busy |= bus.busy;
    bus.start = 1'b0; bus.md_op = 3'd0;
    @(negedge clk);
    seen_busy |= bus.busy;
    n_checks++; if (bus.hi !== 32'hCAFE_BABE) begin n_errors++; $display("FAIL mthi_hi got=%h exp=cafebabe", bus.hi); end
    n_checks++; if (bus.lo !== 32'h0000_1234) begin n_errors++; $display("FAIL mthi_lo got=%h exp=00001234", bus.lo); end
    n_checks++; if (seen_busy !== 1'b0) begin n_errors++; $display("FAIL move_busy got=%b exp=0", seen_busy); end
    // unknown op: nothing changes
    do_start(3'd7, 32'h1111_1111, 32'h2222_2222);
    n_checks++; if (bus.busy !== 1'b0 || bus.hi !== 32'hCAFE_BABE || bus.lo !== 32'h0000_1234)
      begin n_errors++; $display("FAIL nop_op got busy=%b hi=%h lo=%h exp busy=0 hi=cafebabe lo=00001234", bus.busy, bus.hi, bus.lo); end
  endtask

  task automatic test_mult();
    logic [2:0]  op_t [6] = '{MD_MULT, MD_MULTU, MD_MULT, MD_MULTU, MD_MULT, MD_MULTU};
    logic [31:0] a_t  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] b_t  [6] = '{32'h0000_0005, 32'h0000_0002, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] hi_t [6] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h4000_0000, 32'h0000_0000, 32'hFFFF_FFFE};
    logic [31:0] lo_t [6] = '{32'hFFFF_FFF1, 32'hFFFF_FFFE, 32'h8000_0001, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001};
    int cyc;
    for (int i = 0; i < 6; i++) begin
      do_start(op_t[i], a_t[i], b_t[i]);
      if (i == 0) begin
        n_checks++; if (bus.hi !== 32'hCAFE_BABE || bus.lo !== 32'h0000_1234)
          begin n_errors++; $display("FAIL mult_hold got hi=%h lo=%h exp hi=cafebabe lo=00001234", bus.hi, bus.lo); end
        n_checks++; if (bus.state !== ST_MUL) begin n_errors++; $display("FAIL mult_state got=%0d exp=1", bus.state); end
      end
      wait_done(cyc);
      n_checks++; if (cyc != 5) begin n_errors++; $display("FAIL mult%0d_cycles got=%0d exp=5", i, cyc); end
      n_checks++; if (bus.hi !== hi_t[i]) begin n_errors++; $display("FAIL mult%0d_hi got=%h exp=%h", i, bus.hi, hi_t[i]); end
      n_checks++; if (bus.lo !== lo_t[i]) begin n_errors++; $display("FAIL mult%0d_lo got=%h exp=%h", i, bus.lo, lo_t[i]); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  op_t [8] = '{MD_DIV, MD_DIVU, MD_DIVU, MD_DIV, MD_DIV, MD_DIV, MD_DIVU, MD_DIVU};
    logic [31:0] a_t  [8] = '{32'hFFFF_FFF9, 32'd7, 32'd7, 32'h8000_0000, 32'd7, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 32'd100};
    logic [31:0] b_t  [8] = '{32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 32'h10, 32'd7};
    logic [31:0] lo_t [8] = '{32'hFFFF_FFFD, 32'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0FFF_FFFF, 32'd14};
    logic [31:0] hi_t [8] = '{32'hFFFF_FFFF, 32'd1, 32'd7, 32'd0, 32'd1, 32'hFFFF_FFF7, 32'hF, 32'd2};
    int cyc;
    for (int i = 0; i < 8; i++) begin
      do_start(op_t[i], a_t[i], b_t[i]);
      wait_done(cyc);
      n_checks++; if (cyc != 32) begin n_errors++; $display("FAIL div%0d_cycles got=%0d exp=32", i, cyc); end
      n_checks++; if (bus.lo !== lo_t[i]) begin n_errors++; $display("FAIL div%0d_lo got=%h exp=%h", i, bus.lo, lo_t[i]); end
      n_checks++; if (bus.hi !== hi_t[i]) begin n_errors++; $display("FAIL div%0d_hi got=%h exp=%h", i, bus.hi, hi_t[i]); end
    end
  endtask

  task automatic test_ignore_busy();
    int cyc;
    logic [31:0] hi_mid;
    cyc = 0;
    hi_mid = 32'h0;
    do_start(MD_DIVU, 32'd1000, 32'd3);
    for (int i = 0; i < 100; i++) begin
      if (!bus.busy) break;
      cyc++;
      if (i == 4)  begin bus.start = 1'b1; bus.md_op = MD_MTHI; bus.a = 32'hDEAD_0000; end
      if (i == 5)  begin bus.start = 1'b0; bus.md_op = 3'd0; end
      if (i == 7)  hi_mid = bus.hi;
      if (i == 10) begin bus.start = 1'b1; bus.md_op = MD_MULT; bus.a = 32'd3; bus.b = 32'd3; end
      if (i == 11) begin bus.start = 1'b0; bus.md_op = 3'd0; end
      @(negedge clk);
    end
    n_checks++; if (hi_mid !== 32'd2) begin n_errors++; $display("FAIL ign_hi_mid got=%h exp=00000002", hi_mid); end
    n_checks++; if (cyc != 32) begin n_errors++; $display("FAIL ign_cycles got=%0d exp=32", cyc); end
    n_checks++; if (bus.lo !== 32'h0000_014D) begin n_errors++; $display("FAIL ign_lo got=%h exp=0000014d", bus.lo); end
    n_checks++; if (bus.hi !== 32'h0000_0001) begin n_errors++; $display("FAIL ign_hi got=%h exp=00000001", bus.hi); end
    repeat (3) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0 || bus.state !== ST_IDLE)
      begin n_errors++; $display("FAIL ign_idle got busy=%b state=%0d exp busy=0 state=0", bus.busy, bus.state); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    do_start(MD_DIV, 32'hFFFF_FF9C, 32'd3);
    repeat (9) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    n_checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0)
      begin n_errors++; $display("FAIL rstmid_hilo got hi=%h lo=%h exp hi=00000000 lo=00000000", bus.hi, bus.lo); end
    n_checks++; if (bus.state !== ST_IDLE) begin n_errors++; $display("FAIL rstmid_state got=%0d exp=0", bus.state); end
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    n_checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0)
      begin n_errors++; $display("FAIL rstmid_nowrite got hi=%h lo=%h exp hi=00000000 lo=00000000", bus.hi, bus.lo); end
    do_start(MD_MULT, 32'd6, 32'd7);
    wait_done(cyc);
    n_checks++; if (cyc != 5) begin n_errors++; $display("FAIL post_rst_cycles got=%0d exp=5", cyc); end
    n_checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0000_002A)
      begin n_errors++; $display("FAIL post_rst_mult got hi=%h lo=%h exp hi=00000000 lo=0000002a", bus.hi, bus.lo); end
  endtask

  // back-to-back: MTLO issued on the first free cycle after a multiply
  task automatic test_back_to_back();
    int cyc;
    do_start(MD_MULTU, 32'h0001_0000, 32'h0001_0000);
    wait_done(cyc);
    do_start(MD_MTLO, 32'h5555_AAAA, 32'h0);
    n_checks++; if (bus.hi !== 32'h0000_0001 || bus.lo !== 32'h5555_AAAA)
      begin n_errors++; $display("FAIL b2b got hi=%h lo=%h exp hi=00000001 lo=5555aaaa", bus.hi, bus.lo); end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.md_op = 3'd0;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    test_reset();
    test_move();
    test_mult();
    test_div();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
